// File: rtl/calc_pkg.sv
// Shared types and constants for the signed binary to sign+BCD converter.
// Optional feature macro used by the converter top: BCD_LZ_BLANK_EN.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int          BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_BLANK   = 4'hF;

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD digit correction step for shift-add-3: digits of 5 or more get 3 added
// so the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  localparam logic [BCD_DIGIT_W-1:0] FIVE  = BCD_DIGIT_W'(5);
  localparam logic [BCD_DIGIT_W-1:0] THREE = BCD_DIGIT_W'(3);

  assign digit_out = (digit_in >= FIVE) ? (digit_in + THREE) : digit_in;

endmodule

// File: rtl/signed_bcd_converter.sv
// Sequential two's-complement to sign + BCD converter, one magnitude bit per clock.
// Define BCD_LZ_BLANK_EN to replace leading zero digits (above the ones digit) with the blank code.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// ABS   | form unsigned magnitude, clear BCD accumulator
// SHIFT | IN_W add-3/shift iterations
// DONE  | result held on out_* until out_ready
module signed_bcd_converter
  import calc_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_W-1:0]                 in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sign,
  output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] out_bcd
);

  localparam int ACC_W = BCD_DIGIT_W * BCD_DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W-1:0]  MAG_ONE  = IN_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  conv_state_t state_q, state_d;

  logic [IN_W-1:0]  data_q;
  logic             sign_q;
  logic [IN_W-1:0]  mag_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             out_sign_q;
  logic [ACC_W-1:0] out_bcd_q;

  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W+IN_W-1:0] shift_w;
  logic [ACC_W-1:0]      acc_next;
  logic [IN_W-1:0]       mag_next;
  logic [ACC_W-1:0]      acc_disp;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_in  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shift_w  = {acc_adj, mag_q} << 1;
  assign acc_next = shift_w[ACC_W+IN_W-1:IN_W];
  assign mag_next = shift_w[IN_W-1:0];

`ifdef BCD_LZ_BLANK_EN
  // Blank from the most significant digit down until the first nonzero digit.
  always_comb begin
    logic lead;
    lead     = 1'b1;
    acc_disp = acc_next;
    for (int d = BCD_DIGITS - 1; d >= 1; d--) begin
      if (lead && (acc_next[d*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
        acc_disp[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign acc_disp = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = ABS;
      ABS:   state_d = SHIFT;
      SHIFT: if (bit_cnt_q == '0) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      out_sign_q <= 1'b0;
      out_bcd_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            sign_q <= in_data[IN_W-1];
          end
        end
        ABS: begin
          // The most negative value maps to 2^(IN_W-1), which still fits unsigned.
          mag_q     <= sign_q ? (~data_q + MAG_ONE) : data_q;
          acc_q     <= '0;
          bit_cnt_q <= CNT_LAST;
        end
        SHIFT: begin
          acc_q     <= acc_next;
          mag_q     <= mag_next;
          bit_cnt_q <= bit_cnt_q - CNT_ONE;
          if (bit_cnt_q == '0) begin
            out_bcd_q  <= acc_disp;
            out_sign_q <= sign_q & (|acc_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed vector bench for signed_bcd_converter; honours BCD_LZ_BLANK_EN for expected values.
module tb_signed_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [11:0] out_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  signed_bcd_converter #(.IN_W(8), .BCD_DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_bcd   (out_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        exp_sign;
    logic [11:0] exp_bcd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] disp_model(input logic [11:0] raw);
    logic [11:0] r;
    r = raw;
`ifdef BCD_LZ_BLANK_EN
    if (raw[11:8] == 4'h0) begin
      r[11:8] = 4'hF;
      if (raw[7:4] == 4'h0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Full transaction; hold_cycles>0 keeps out_ready low and pushes a stray in_valid meanwhile.
  task automatic convert(input logic [7:0] d, input logic exp_sign, input logic [11:0] exp_bcd,
                         input bit ready_early, input int hold_cycles);
    int n;
    logic        s0;
    logic [11:0] b0;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_start", in_ready, 1);
    out_ready = ready_early;
    in_valid  = 1'b1;
    in_data   = d;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check($sformatf("latency_edges_%02h", d), n, 9);
    check($sformatf("sign_%02h", d), out_sign, exp_sign);
    check($sformatf("bcd_%02h", d), out_bcd, disp_model(exp_bcd));
    if (hold_cycles > 0) begin
      s0 = out_sign;
      b0 = out_bcd;
      in_valid = 1'b1;
      in_data  = 8'h11;
      for (int i = 0; i < hold_cycles; i++) begin
        @(posedge clk); #1;
        check("hold_stable", {out_valid, in_ready, out_sign, out_bcd},
              {1'b1, 1'b0, s0, b0});
      end
      in_valid = 1'b0;
    end
    if (!ready_early) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_idle", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    vecs[0]  = '{8'h2A, 1'b0, 12'h042};
    vecs[1]  = '{8'hC8, 1'b1, 12'h056};
    vecs[2]  = '{8'h80, 1'b1, 12'h128};
    vecs[3]  = '{8'h40, 1'b0, 12'h064};
    vecs[4]  = '{8'h00, 1'b0, 12'h000};
    vecs[5]  = '{8'h7F, 1'b0, 12'h127};
    vecs[6]  = '{8'hFF, 1'b1, 12'h001};
    vecs[7]  = '{8'h05, 1'b0, 12'h005};
    vecs[8]  = '{8'h64, 1'b0, 12'h100};
    vecs[9]  = '{8'h9C, 1'b1, 12'h100};
    vecs[10] = '{8'h0A, 1'b0, 12'h010};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1;
    check("reset_outputs", {in_ready, out_valid, out_sign, out_bcd}, {1'b1, 1'b0, 1'b0, 12'h000});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].data, vecs[i].exp_sign, vecs[i].exp_bcd, (i % 2) == 0, 0);
    end

    // Backpressure: result must hold for 20 cycles and the stray operand must be dropped.
    convert(8'hD6, 1'b1, 12'h042, 1'b0, 20);
    repeat (3) @(posedge clk);
    #1;
    check("stray_input_ignored", {in_ready, out_valid}, 2'b10);

    // Abort mid-SHIFT: previous result is nonzero, so a cleared out_bcd shows the reset took effect.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_abort_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {in_ready, out_valid, out_sign, out_bcd}, {1'b1, 1'b0, 1'b0, 12'h000});
    @(negedge clk);
    rst_n = 1'b1;
    convert(8'h07, 1'b0, 12'h007, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
